// File: rtl/uart_tx.sv
// UART transmitter: start + DATA_W data bits (LSB first) + optional parity + stop bits, one holding byte.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              CLK100MHZ,
  input  logic              RST_N,
  input  logic              CLK_BPS,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TX,
  output logic              TX_BUSY,
  output logic              TX_DONE
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx: parameter out of range");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic r_par;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             r_state;
  logic               r_bps_prev;
  logic [DATA_W-1:0]  r_hold;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_stop_cnt;
  logic               r_ready;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic w_tick;
  logic w_last_stop;
  logic w_load;

  assign w_tick      = CLK_BPS & ~r_bps_prev;
  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));
  // Holding full is !r_ready; a load either leaves IDLE or chains straight out of the last stop bit.
  assign w_load      = w_tick && !r_ready && ((r_state == S_IDLE) || w_last_stop);

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_bps_prev <= 1'b1;
      r_hold     <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_ready    <= 1'b1;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_bps_prev <= CLK_BPS;
      r_done     <= 1'b0;

      if (TX_VALID && r_ready) begin
        r_hold  <= TX_DATA;
        r_ready <= 1'b0;
      end

      if (w_tick) begin
        case (r_state)
          S_START: begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= CNT_W'(1);
            r_state   <= S_DATA;
          end
          S_DATA: begin
            if (r_bit_cnt == CNT_W'(DATA_W)) begin
`ifdef UART_TX_PARITY_EN
              r_tx       <= r_par;
              r_state    <= S_PARITY;
`else
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
`endif
          S_STOP: begin
            if (w_last_stop) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (w_load) begin
        r_shift   <= r_hold;
        r_ready   <= 1'b1;
        r_bit_cnt <= '0;
        r_tx      <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
        r_par     <= (^r_hold) ^ (PARITY_ODD != 0);
`endif
      end
    end
  end

  assign TX_READY = r_ready;
  assign TX       = r_tx;
  assign TX_BUSY  = r_busy;
  assign TX_DONE  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames against a bit-level frame model.
// CLK_BPS is driven with a short bit period so whole frames fit in a small cycle budget.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int DW    = 8;
  localparam int SB    = 1;
  localparam int PODD  = 0;
  localparam int BT    = 16;
  localparam int CLKP  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PB    = 1;
`else
  localparam int PB    = 0;
`endif
  localparam int FRAME = 1 + DW + PB + SB;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          bps   = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready, tx, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.DATA_W(DW), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .CLK100MHZ(clk),
    .RST_N    (rst_n),
    .CLK_BPS  (bps),
    .TX_DATA  (data),
    .TX_VALID (valid),
    .TX_READY (ready),
    .TX       (tx),
    .TX_BUSY  (busy),
    .TX_DONE  (done)
  );

  always #(CLKP/2) clk = ~clk;

  always begin
    repeat (BT/2) @(negedge clk);
    bps = ~bps;
  end

  // Line level expected during bit slot k of a frame carrying d.
  function automatic logic model_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (PB == 1 && k == DW + 1) return (^d) ^ (PODD != 0);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [DW-1:0] d, input string tag);
    int n;
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    n = 0;
    while (ready !== 1'b0 && n < 4*BT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accepted"}, ready, 0);
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 4*BT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_bit"}, tx, 0);
    chk({tag, "_latency_ok"}, (n <= BT), 1);
  endtask

  // Entered on the negedge of the first start-bit cycle; leaves on the negedge where TX_DONE is high.
  task automatic check_frame(input logic [DW-1:0] d, input logic queued, input string tag);
    int dones;
    dones = 0;
    for (int t = 1; t <= FRAME*BT; t++) begin
      @(negedge clk);
      if (t == 1) valid = 1'b0;
      if (t < FRAME*BT) begin
        if (done === 1'b1) dones++;
        if (t % BT == BT/2) begin
          chk($sformatf("%s_bit%0d", tag, t/BT), tx, model_bit(d, t/BT));
          chk($sformatf("%s_busy%0d", tag, t/BT), busy, 1);
        end
      end
    end
    chk({tag, "_no_early_done"}, dones, 0);
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_tx_after"}, tx, queued ? 0 : 1);
    chk({tag, "_busy_after"}, busy, queued ? 1 : 0);
  endtask

  initial begin
    logic [DW-1:0] d1, d2;
    int lows, dones;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0x55
    offer(8'h55, "f55");
    valid = 1'b0;
    wait_fall("f55");
    check_frame(8'h55, 1'b0, "f55");
    @(negedge clk);
    chk("f55_done_one_cycle", done, 0);
    chk("f55_ready_idle", ready, 1);

    // Back-to-back with TX_VALID held
    offer(8'hA5, "fa5");
    data = 8'h3C;
    wait_fall("fa5");
    chk("fa5_ready_after_tick", ready, 1);
    check_frame(8'hA5, 1'b1, "fa5");
    check_frame(8'h3C, 1'b0, "f3c");

    // Reset during data bit 4 of 0xFF with a second byte queued
    repeat (3) @(negedge clk);
    offer(8'hFF, "fff");
    data = 8'h12;
    wait_fall("fff");
    @(negedge clk);
    valid = 1'b0;
    repeat (5*BT + BT/2 - 1) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_ready", ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_ready", ready, 1);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    dones = 0;
    for (int t = 0; t < 3*FRAME*BT; t++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    chk("post_rst_tx_idle", lows, 0);
    chk("post_rst_no_done", dones, 0);
    d1 = DW'($urandom);
    offer(d1, "post_rst");
    valid = 1'b0;
    wait_fall("post_rst");
    check_frame(d1, 1'b0, "post_rst");

    // Random bytes, idle gaps and back-to-back pairs
    for (int i = 0; i < 8; i++) begin
      d1 = DW'($urandom);
      d2 = DW'($urandom);
      repeat ($urandom_range(1, 2*BT)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        offer(d1, $sformatf("r%0da", i));
        data = d2;
        wait_fall($sformatf("r%0da", i));
        check_frame(d1, 1'b1, $sformatf("r%0da", i));
        check_frame(d2, 1'b0, $sformatf("r%0db", i));
      end else begin
        offer(d1, $sformatf("r%0d", i));
        valid = 1'b0;
        wait_fall($sformatf("r%0d", i));
        check_frame(d1, 1'b0, $sformatf("r%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
